output_port_allocator: RTL

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

---
 rtl/router_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/output_port_allocator.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: port numbering, route index width, output FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package router_pkg;

   localparam int ROUTE_WIDTH = 3;

   typedef enum logic [ROUTE_WIDTH-1:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4
   } port_e;

   typedef enum logic {
      OUT_IDLE   = 1'b0,
      OUT_LOCKED = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (wrapping) gets a one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;

   // Scan upward from the pointer with wrap-around; the first requester wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            gnt[(int'(ptr) + k) % N] = 1'b1;
            found                    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output allocator: per-output round-robin/lock FSM with downstream credit counting.
// Latency: grant/send_out/out_sel are combinational (zero-cycle); state moves on the clk_noc edge.
// Backpressure: an output only sends while it holds a credit; non-granted inputs simply keep requesting.
module output_port_allocator
   import router_pkg::*;
#(
   parameter int NUM_INPUTS        = 5,
   parameter int NUM_OUTPUTS       = 5,
   parameter int FLIT_BUFFER_DEPTH = 1,
   parameter int ROUTE_WIDTH       = router_pkg::ROUTE_WIDTH
) (
   input  logic                                           clk_noc,
   input  logic                                           rst_noc,
   input  logic [0:NUM_INPUTS-1]                          req_valid,
   input  logic [0:NUM_INPUTS-1][ROUTE_WIDTH-1:0]         req_route,
   input  logic [0:NUM_INPUTS-1]                          req_is_tail,
   input  logic [0:NUM_INPUTS-1][0:NUM_OUTPUTS-1]         disable_turns,
   input  logic [0:NUM_OUTPUTS-1]                         credit_in,
   output logic [0:NUM_INPUTS-1]                          grant,
   output logic [0:NUM_OUTPUTS-1]                         send_out,
   output logic [0:NUM_OUTPUTS-1][$clog2(NUM_INPUTS)-1:0] out_sel,
   output logic [0:NUM_OUTPUTS-1]                         out_locked,
   output logic                                           err_sticky
);

   localparam int            SEL_W      = $clog2(NUM_INPUTS);
   localparam int            CW         = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);

   out_state_e            state_q  [NUM_OUTPUTS];
   out_state_e            state_d  [NUM_OUTPUTS];
   logic [SEL_W-1:0]      owner_q  [NUM_OUTPUTS];
   logic [SEL_W-1:0]      owner_d  [NUM_OUTPUTS];
   logic [SEL_W-1:0]      ptr_q    [NUM_OUTPUTS];
   logic [SEL_W-1:0]      ptr_d    [NUM_OUTPUTS];
   logic [CW-1:0]         credit_q [NUM_OUTPUTS];
   logic [CW-1:0]         credit_d [NUM_OUTPUTS];
   logic                  err_q;
   logic                  err_d;

   logic [NUM_INPUTS-1:0] elig     [NUM_OUTPUTS];
   logic [NUM_INPUTS-1:0] arb_gnt  [NUM_OUTPUTS];
   logic [NUM_INPUTS-1:0] win_oh   [NUM_OUTPUTS];
   logic [SEL_W-1:0]      win_idx  [NUM_OUTPUTS];

   // Per-output request columns: valid, routed here, and the turn is allowed.
   always_comb begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         elig[o] = '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            elig[o][i] = req_valid[i] && (int'(req_route[i]) == o) && !disable_turns[i][o];
         end
      end
   end

   for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_arb
      rr_arbiter #(
         .N  (NUM_INPUTS),
         .PW (SEL_W)
      ) u_rr (
         .req (elig[g]),
         .ptr (ptr_q[g]),
         .gnt (arb_gnt[g])
      );
   end

   // Winner per output: round-robin when idle, only the owner when locked, nobody without credit or in reset.
   always_comb begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         win_oh[o]  = '0;
         win_idx[o] = '0;
         if (!rst_noc && (credit_q[o] != '0)) begin
            if (state_q[o] == OUT_IDLE) begin
               win_oh[o] = arb_gnt[o];
            end else begin
               win_oh[o][owner_q[o]] = elig[o][owner_q[o]];
            end
         end
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (win_oh[o][i]) begin
               win_idx[o] = SEL_W'(i);
            end
         end
      end
   end

   // Crossbar and pop outputs; routes are unique per input so the OR never merges two grants.
   always_comb begin
      grant      = '0;
      send_out   = '0;
      out_sel    = '0;
      out_locked = '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         send_out[o]   = |win_oh[o];
         out_sel[o]    = win_idx[o];
         out_locked[o] = !rst_noc && (state_q[o] == OUT_LOCKED);
         for (int i = 0; i < NUM_INPUTS; i++) begin
            grant[i] = grant[i] | win_oh[o][i];
         end
      end
   end

   assign err_sticky = err_q;

   // Next state: lock/unlock on head/tail, advance pointer on idle grants, count credits, latch errors.
   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (req_valid[i]) begin
            if (int'(req_route[i]) >= NUM_OUTPUTS) begin
               err_d = 1'b1;
            end else if (disable_turns[i][req_route[i]]) begin
               err_d = 1'b1;
            end
         end
      end
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         state_d[o]  = state_q[o];
         owner_d[o]  = owner_q[o];
         ptr_d[o]    = ptr_q[o];
         credit_d[o] = credit_q[o];
         if (send_out[o]) begin
            if (state_q[o] == OUT_IDLE) begin
               ptr_d[o] = (int'(win_idx[o]) == NUM_INPUTS - 1) ? '0 : win_idx[o] + SEL_W'(1);
               if (!req_is_tail[win_idx[o]]) begin
                  state_d[o] = OUT_LOCKED;
                  owner_d[o] = win_idx[o];
               end
            end else if (req_is_tail[win_idx[o]]) begin
               state_d[o] = OUT_IDLE;
            end
         end
         // A return in the same cycle as a send is absorbed by that send, so only an
         // unmatched return into a full counter is an overflow.
         if (send_out[o] && !credit_in[o]) begin
            credit_d[o] = credit_q[o] - CW'(1);
         end else if (!send_out[o] && credit_in[o]) begin
            if (credit_q[o] == CREDIT_MAX) begin
               err_d = 1'b1;
            end else begin
               credit_d[o] = credit_q[o] + CW'(1);
            end
         end
      end
   end

   // State registers; reset drops every lock at once and refills the credit counters.
   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            state_q[o]  <= OUT_IDLE;
            owner_q[o]  <= '0;
            ptr_q[o]    <= '0;
            credit_q[o] <= CREDIT_MAX;
         end
         err_q <= 1'b0;
      end else begin
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            state_q[o]  <= state_d[o];
            owner_q[o]  <= owner_d[o];
            ptr_q[o]    <= ptr_d[o];
            credit_q[o] <= credit_d[o];
         end
         err_q <= err_d;
      end
   end

endmodule
